// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// PLL supervisor and staggered reset sequencer, clocked from the PLL
// reference clock. It pulses the PLL reset, waits for a filtered lock, and
// then releases the downstream reset channels one at a time, bit 0 first.
// A lock timeout retries the PLL. A lock loss after release starts puts
// every channel back into reset and restarts the whole sequence.
//
// Ports
//   clock          reference clock
//   reset          synchronous active-high reset
//   pll_lock_i     asynchronous PLL lock, 2-flop synchronised internally
//   pll_rst_o      PLL reset, active-high
//   rst_o          per-channel resets, active-high, bit 0 released first
//   ready_o        high once every channel is released
//   lock_lost_o    one-cycle pulse when lock drops during release or run
//   retry_count_o  number of lock-timeout retries, saturates at 255
//
// State table
//   state         | meaning
//   ST_PLL_RESET  | pll_rst_o held high for PLL_RST_CYCLES cycles
//   ST_WAIT_LOCK  | PLL running, waiting for lock_s, timeout armed
//   ST_FILTER     | lock seen, counting consecutive high cycles
//   ST_RELEASE    | channels being released one per RELEASE_GAP cycles
//   ST_RUN        | all channels released, watching for lock loss

module pll_reset_sequencer #(
    parameter int NUM_RESETS     = 3,
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_FILTER    = 16,
    parameter int LOCK_TIMEOUT   = 1000,
    parameter int RELEASE_GAP    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_lock_i,
    output logic                  pll_rst_o,
    output logic [NUM_RESETS-1:0] rst_o,
    output logic                  ready_o,
    output logic                  lock_lost_o,
    output logic [7:0]            retry_count_o
);

    // One shared counter serves every timed state, so it is sized for the
    // longest interval.
    localparam int MAX_PF  = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
    localparam int MAX_TG  = (LOCK_TIMEOUT > RELEASE_GAP) ? LOCK_TIMEOUT : RELEASE_GAP;
    localparam int CNT_MAX = (MAX_PF > MAX_TG) ? MAX_PF : MAX_TG;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PRC_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LF_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  lock_meta_q;
    logic                  lock_s_q;
    logic                  pll_rst_q;
    logic [NUM_RESETS-1:0] rst_q;
    logic                  ready_q;
    logic                  lock_lost_q;
    logic [7:0]            retry_q;

    // Releasing a channel is a left shift with zero fill. Channels therefore
    // leave reset strictly in bit order, and the last release is the one that
    // leaves the vector empty.
    logic [NUM_RESETS-1:0] rst_next;
    assign rst_next = rst_q << 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            rst_q       <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= 8'd0;
        end else begin
            lock_lost_q <= 1'b0;
            case (state_q)
                ST_PLL_RESET: begin
                    pll_rst_q <= 1'b1;
                    rst_q     <= '1;
                    ready_q   <= 1'b0;
                    if (cnt_q == PRC_LAST) begin
                        state_q   <= ST_WAIT_LOCK;
                        pll_rst_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock is tested first so that a lock arriving on the
                    // timeout cycle is not thrown away.
                    if (lock_s_q) begin
                        state_q <= ST_FILTER;
                        cnt_q   <= '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= ST_PLL_RESET;
                        pll_rst_q <= 1'b1;
                        cnt_q     <= '0;
                        if (retry_q != 8'hFF) begin
                            retry_q <= retry_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_FILTER: begin
                    // A drop during filtering only restarts the timeout.
                    // The PLL is not reset, so it is not a retry.
                    if (!lock_s_q) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == LF_LAST) begin
                        cnt_q <= '0;
                        rst_q <= rst_next;
                        if (rst_next == '0) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_RELEASE: begin
                    if (!lock_s_q) begin
                        state_q     <= ST_PLL_RESET;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        rst_q       <= '1;
                        ready_q     <= 1'b0;
                        lock_lost_q <= 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        rst_q <= rst_next;
                        if (rst_next == '0) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_q     <= ST_PLL_RESET;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        rst_q       <= '1;
                        ready_q     <= 1'b0;
                        lock_lost_q <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= ST_PLL_RESET;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                    rst_q     <= '1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o     = pll_rst_q;
    assign rst_o         = rst_q;
    assign ready_o       = ready_q;
    assign lock_lost_o   = lock_lost_q;
    assign retry_count_o = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Parametrised PLL supervisor and reset sequencer, clocked from the PLL reference clock. It drives the PLL reset input and watches the PLL lock output. It releases `NUM_RESETS` downstream reset channels in a fixed staggered order once lock has been stable for a programmable time. If lock is not achieved it retries the PLL, and if lock is lost it re-asserts every channel and restarts the sequence. It sits between the ECP5 PLL wrapper and the core/peripheral reset trees.

## Interface
Parameters:
- `NUM_RESETS`, 3: number of reset channels, ≥1.
- `PLL_RST_CYCLES`, 4: width in cycles of each `pll_rst_o` pulse, ≥1.
- `LOCK_FILTER`, 16: consecutive synchronised-high lock cycles required before release, ≥1.
- `LOCK_TIMEOUT`, 1000: maximum cycles in WAIT_LOCK before a PLL retry, ≥2.
- `RELEASE_GAP`, 8: cycles between successive channel releases, ≥1.

Ports:
- `clock`  in  1  reference clock.
- `reset`  in  1  synchronous, active-high.
- `pll_lock_i`  in  1  asynchronous PLL lock; passes through a 2-flop synchroniser (`lock_s`).
- `pll_rst_o`  out  1  PLL reset, active-high.
- `rst_o`  out  NUM_RESETS  per-channel reset, active-high; bit 0 released first.
- `ready_o`  out  1  high when all channels are released.
- `lock_lost_o`  out  1  one-cycle pulse on loss of lock during RELEASE or RUN.
- `retry_count_o`  out  8  count of timeout retries, saturating at 255.

## Operation
- All outputs are registered. Reset values: `pll_rst_o`=1, `rst_o`=all ones, `ready_o`=0, `lock_lost_o`=0, `retry_count_o`=0, synchroniser=0, state=PLL_RESET, counters=0.
- Counter width is clog2 of the largest of the timing parameters. The channel index width is clog2(NUM_RESETS), minimum 1.
- **PLL_RESET:**
  - `pll_rst_o`=1 and `rst_o`=all ones.
  - After PLL_RST_CYCLES cycles, go to WAIT_LOCK with the counter cleared.
- **WAIT_LOCK:**
  - `pll_rst_o`=0; the counter increments every cycle.
  - If `lock_s`=1, go to FILTER with the counter cleared.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1, go to PLL_RESET and increment `retry_count_o` (saturating).
  - If `lock_s`=1 on the timeout cycle, the lock wins.
- **FILTER:**
  - If `lock_s`=0, return to WAIT_LOCK with the timeout counter restarted; this is not a retry.
  - After LOCK_FILTER consecutive `lock_s`=1 cycles, go to RELEASE.
- **RELEASE:**
  - `rst_o[0]` deasserts on entry.
  - `rst_o[k]` deasserts k·RELEASE_GAP cycles after `rst_o[0]`.
  - When `rst_o[NUM_RESETS-1]` deasserts, enter RUN and set `ready_o`=1 on the same edge.
  - If NUM_RESETS=1, go straight from FILTER to RUN.
- **RUN:** hold until `lock_s`=0.
- **Lock loss in RELEASE or RUN:**
  - On the same edge: `rst_o`=all ones, `ready_o`=0, `lock_lost_o` pulses, `pll_rst_o`=1, go to PLL_RESET.
  - `retry_count_o` is unchanged.
- Released channels never re-deassert out of order; reassertion is always all channels at once.
- `reset` mid-sequence returns every register to its reset value on the next edge.
- `retry_count_o` is cleared only by `reset`.

## Timing
- Edge e0 is the first edge that samples `pll_lock_i`=1; `lock_s` is high after e1.
- With lock steady from WAIT_LOCK:
  - FILTER is entered at e2.
  - `rst_o[0]` deasserts at edge e0+LOCK_FILTER+2.
  - `ready_o` rises at edge e0+LOCK_FILTER+2+(NUM_RESETS-1)·RELEASE_GAP.
- Lock loss: with `pll_lock_i`=0 first sampled at e0, the reassert, `lock_lost_o` and `pll_rst_o` outputs change at e0+2.
- From `reset` deassertion, the first WAIT_LOCK cycle follows exactly PLL_RST_CYCLES cycles of `pll_rst_o`=1.
- A retry pulse is PLL_RST_CYCLES wide and begins on the edge after timeout cycle LOCK_TIMEOUT-1.

## Test plan
Defaults apply unless stated.
- **Clean lock:** lock rises 20 cycles after reset.
  - `pll_rst_o` is high for exactly 4 cycles.
  - `rst_o` steps 3'b110, 3'b100, 3'b000 at e0+18, e0+26 and e0+34.
  - `ready_o` rises at e0+34.
- **Glitchy lock:** lock pulses high for 10 cycles, drops, then stays high.
  - FILTER aborts and no channel is released.
  - Release occurs 18 edges after the final rise; `retry_count_o`=0.
- **Timeout:** LOCK_TIMEOUT=50, lock held low.
  - `pll_rst_o` issues a 4-cycle pulse every 54 cycles.
  - `retry_count_o` increments 1, 2, 3…; forcing 300 retries shows saturation at 255.
- **Lock loss in RUN:** lock drops at e0.
  - At e0+2: `rst_o`=3'b111, `ready_o`=0, one-cycle `lock_lost_o`, `pll_rst_o`=1.
  - Relock then repeats the full staggered release.
- **Lock loss mid-RELEASE:** lock drops after `rst_o`=3'b100.
  - All channels reassert together and bit 2 never deasserts.
- **Reset mid-RELEASE:** `reset`=1 for 1 cycle.
  - Next edge gives all reset values, including `retry_count_o`=0.
  - NUM_RESETS=1 variant: `ready_o` and `rst_o[0]` change on the same edge.
